// File: rtl/conv_acc_pkg.sv
// rtl/conv_acc_pkg.sv - shared constants and accelerator state encodings
// Purpose: definitions shared by the convolution accelerator sequencer and its helpers.
//   acc_state_e : 2-bit state driven to the accelerator (CTRL/WEIGHT/FULLUP/CONV)
//   PIX_W       : pixel width
//   W_BEATS     : weight words per load
//   TILE_BEATS  : image beats per tile
package conv_acc_pkg;

  localparam int PIX_W      = 16;
  localparam int W_BEATS    = 9;
  localparam int TILE_BEATS = 16;

  typedef enum logic [1:0] {
    ACC_CTRL   = 2'b00,
    ACC_WEIGHT = 2'b01,
    ACC_FULLUP = 2'b10,
    ACC_CONV   = 2'b11
  } acc_state_e;

endpackage

// File: rtl/conv_acc_ctrl_wdog.sv
// rtl/conv_acc_ctrl_wdog.sv - loadable down-counter with expire flag
// Purpose: watchdog for the done wait.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load load_val_i (has priority over counting)
//   load_val_i    : value to load
//   en_i          : decrement while nonzero
//   expired_o     : counter is zero
module conv_acc_ctrl_wdog #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/conv_acc_ctrl.sv
// rtl/conv_acc_ctrl.sv - job sequencer in front of the 4xPE convolution accelerator
// Purpose: per job, clear the accelerator, load 9 weight words, stream N tiles of
// image beats, raise last-input, wait for done (with watchdog) and forward results.
// Optional macro CONV_ACC_CTRL_PERF_EN adds o_perf_cycles / o_perf_stall counters.
// Ports:
//   clk, rst (async active-low)
//   i_start, i_tile_num          : job request (tile_num 0 ignored)
//   o_busy, o_job_done, o_err    : job status (err is a sticky timeout flag)
//   i_w_*, o_w_ready             : weight word stream
//   i_img_*, o_img_ready         : image beat stream
//   o_acc_*                      : registered accelerator drive
//   i_acc_out_*, i_acc_done      : accelerator results / completion
//   o_res_data/valid/cnt         : forwarded result stream and per-job count
module conv_acc_ctrl #(
  parameter int IMG_W      = 144,
  parameter int WGT_W      = 64,
  parameter int OUT_W      = 64,
  parameter int TILE_BEATS = conv_acc_pkg::TILE_BEATS,
  parameter int W_BEATS    = conv_acc_pkg::W_BEATS,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [7:0]       i_tile_num,
  output logic             o_busy,
  output logic             o_job_done,
  output logic             o_err,
  input  logic [WGT_W-1:0] i_w_data,
  input  logic             i_w_valid,
  output logic             o_w_ready,
  input  logic [IMG_W-1:0] i_img_data,
  input  logic             i_img_valid,
  output logic             o_img_ready,
  output logic             o_acc_rst,
  output logic [1:0]       o_acc_state,
  output logic [IMG_W-1:0] o_acc_data,
  output logic             o_acc_data_en,
  output logic             o_acc_last,
  input  logic [OUT_W-1:0] i_acc_out_data,
  input  logic             i_acc_out_en,
  input  logic             i_acc_done,
  output logic [OUT_W-1:0] o_res_data,
  output logic             o_res_valid,
  output logic [15:0]      o_res_cnt
`ifdef CONV_ACC_CTRL_PERF_EN
  ,
  output logic [31:0]      o_perf_cycles,
  output logic [31:0]      o_perf_stall
`endif
);

  import conv_acc_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_LOAD_W = 3'd2;
  localparam logic [2:0] S_FILL   = 3'd3;
  localparam logic [2:0] S_CONV   = 3'd4;
  localparam logic [2:0] S_LAST   = 3'd5;
  localparam logic [2:0] S_WAIT   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]       state_q, state_d;
  logic [3:0]       w_cnt_q, w_cnt_d;
  logic [15:0]      beats_q, beats_d;
  logic             err_q, err_d;
  acc_state_e       acc_state_q, acc_state_d;
  logic [IMG_W-1:0] acc_data_q, acc_data_d;
  logic             acc_en_q, acc_en_d;
  logic             acc_last_q, acc_last_d;
  logic             res_valid_q, res_valid_d;
  logic [OUT_W-1:0] res_data_q, res_data_d;
  logic [15:0]      res_cnt_q, res_cnt_d;

  logic start_ok, w_acc, img_acc, res_take;
  logic wd_load, wd_expired;

  assign start_ok    = (state_q == S_IDLE) && i_start && (i_tile_num != 8'd0);
  assign o_w_ready   = (state_q == S_LOAD_W);
  assign o_img_ready = (state_q == S_CONV) && (beats_q != 16'd0);
  assign w_acc       = o_w_ready && i_w_valid;
  assign img_acc     = o_img_ready && i_img_valid;
  // Results are dropped only while the accelerator is being cleared.
  assign res_take    = (state_q != S_CLR) && i_acc_out_en;

  // Loaded with TIMEOUT-1 on the LAST cycle so it hits zero on the TIMEOUT-th
  // WAIT_DONE cycle; done is checked first on that cycle.
  conv_acc_ctrl_wdog #(.W(WD_W)) u_wdog (
    .clk_i      (clk),
    .rst_ni     (rst),
    .load_i     (wd_load),
    .load_val_i (WD_W'(TIMEOUT - 1)),
    .en_i       (state_q == S_WAIT),
    .expired_o  (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    w_cnt_d     = w_cnt_q;
    beats_d     = beats_q;
    err_d       = err_q;
    acc_state_d = ACC_CTRL;
    acc_data_d  = acc_data_q;
    acc_en_d    = 1'b0;
    acc_last_d  = 1'b0;
    wd_load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d = S_CLR;
          w_cnt_d = 4'd0;
          beats_d = 16'(i_tile_num) * 16'(TILE_BEATS);
          err_d   = 1'b0;
        end
      end
      S_CLR: state_d = S_LOAD_W;
      S_LOAD_W: begin
        // Weight state only accompanies a freshly accepted word: the
        // accelerator writes its weight registers on every weight cycle.
        if (w_acc) begin
          acc_state_d = ACC_WEIGHT;
          acc_data_d  = {{(IMG_W-WGT_W){1'b0}}, i_w_data};
          acc_en_d    = 1'b1;
          if (w_cnt_q == 4'(W_BEATS - 1)) begin
            state_d = S_FILL;
          end else begin
            w_cnt_d = w_cnt_q + 4'd1;
          end
        end
      end
      S_FILL: begin
        acc_state_d = ACC_FULLUP;
        state_d     = S_CONV;
      end
      S_CONV: begin
        acc_state_d = ACC_CONV;
        if (img_acc) begin
          acc_data_d = i_img_data;
          acc_en_d   = 1'b1;
          beats_d    = beats_q - 16'd1;
          if (beats_q == 16'd1) begin
            state_d = S_LAST;
          end
        end
      end
      S_LAST: begin
        acc_state_d = ACC_CONV;
        acc_last_d  = 1'b1;
        wd_load     = 1'b1;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        acc_state_d = ACC_CONV;
        if (i_acc_done) begin
          state_d = S_DONE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_valid_d = res_take;
    res_data_d  = res_take ? i_acc_out_data : res_data_q;
    res_cnt_d   = res_cnt_q;
    if (start_ok) begin
      res_cnt_d = 16'd0;
    end else if (res_take && (res_cnt_q != 16'hFFFF)) begin
      res_cnt_d = res_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      w_cnt_q     <= '0;
      beats_q     <= '0;
      err_q       <= 1'b0;
      acc_state_q <= ACC_CTRL;
      acc_data_q  <= '0;
      acc_en_q    <= 1'b0;
      acc_last_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      w_cnt_q     <= w_cnt_d;
      beats_q     <= beats_d;
      err_q       <= err_d;
      acc_state_q <= acc_state_d;
      acc_data_q  <= acc_data_d;
      acc_en_q    <= acc_en_d;
      acc_last_q  <= acc_last_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_cnt_q   <= res_cnt_d;
    end
  end

  assign o_busy        = (state_q != S_IDLE);
  assign o_job_done    = (state_q == S_DONE);
  assign o_acc_rst     = (state_q == S_CLR);
  assign o_err         = err_q;
  assign o_acc_state   = acc_state_q;
  assign o_acc_data    = acc_data_q;
  assign o_acc_data_en = acc_en_q;
  assign o_acc_last    = acc_last_q;
  assign o_res_valid   = res_valid_q;
  assign o_res_data    = res_data_q;
  assign o_res_cnt     = res_cnt_q;

`ifdef CONV_ACC_CTRL_PERF_EN
  logic [31:0] perf_cyc_q, perf_cyc_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cyc_d   = perf_cyc_q;
    perf_stall_d = perf_stall_q;
    if (start_ok) begin
      perf_cyc_d   = 32'd0;
      perf_stall_d = 32'd0;
    end else begin
      if (o_busy) begin
        perf_cyc_d = perf_cyc_q + 32'd1;
      end
      if ((o_w_ready && !i_w_valid) || (o_img_ready && !i_img_valid)) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cyc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_cyc_q   <= perf_cyc_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign o_perf_cycles = perf_cyc_q;
  assign o_perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_conv_acc_ctrl.sv
// tb/tb_conv_acc_ctrl.sv - randomized self-checking bench for conv_acc_ctrl
module tb_conv_acc_ctrl;

  localparam int IMG_W = 144;
  localparam int WGT_W = 64;
  localparam int OUT_W = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i_start = 1'b0;
  logic [7:0]       i_tile_num = '0;
  logic             o_busy, o_job_done, o_err;
  logic [WGT_W-1:0] i_w_data = '0;
  logic             i_w_valid = 1'b0;
  logic             o_w_ready;
  logic [IMG_W-1:0] i_img_data = '0;
  logic             i_img_valid = 1'b0;
  logic             o_img_ready;
  logic             o_acc_rst;
  logic [1:0]       o_acc_state;
  logic [IMG_W-1:0] o_acc_data;
  logic             o_acc_data_en, o_acc_last;
  logic [OUT_W-1:0] i_acc_out_data = '0;
  logic             i_acc_out_en = 1'b0;
  logic             i_acc_done = 1'b0;
  logic [OUT_W-1:0] o_res_data;
  logic             o_res_valid;
  logic [15:0]      o_res_cnt;
`ifdef CONV_ACC_CTRL_PERF_EN
  logic [31:0]      o_perf_cycles, o_perf_stall;
`endif

  conv_acc_ctrl dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_tile_num(i_tile_num),
    .o_busy(o_busy), .o_job_done(o_job_done), .o_err(o_err),
    .i_w_data(i_w_data), .i_w_valid(i_w_valid), .o_w_ready(o_w_ready),
    .i_img_data(i_img_data), .i_img_valid(i_img_valid), .o_img_ready(o_img_ready),
    .o_acc_rst(o_acc_rst), .o_acc_state(o_acc_state), .o_acc_data(o_acc_data),
    .o_acc_data_en(o_acc_data_en), .o_acc_last(o_acc_last),
    .i_acc_out_data(i_acc_out_data), .i_acc_out_en(i_acc_out_en), .i_acc_done(i_acc_done),
    .o_res_data(o_res_data), .o_res_valid(o_res_valid), .o_res_cnt(o_res_cnt)
`ifdef CONV_ACC_CTRL_PERF_EN
    , .o_perf_cycles(o_perf_cycles), .o_perf_stall(o_perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Scoreboard: words/beats the bench saw accepted, and results it drove.
  typedef struct {
    logic [OUT_W-1:0] d;
    int               c;
  } res_t;

  logic [WGT_W-1:0] wq[$];
  logic [IMG_W-1:0] iq[$];
  res_t             rq[$];

  int n_wgt, n_full, n_conv, n_rst, n_last, n_done;
  int rst_cyc, last_cyc, done_cyc;
  logic [WGT_W-1:0] w_exp;
  logic [IMG_W-1:0] i_exp;
  res_t             r_exp;

  always @(negedge clk) begin
    if (o_acc_rst) begin
      n_rst++;
      rst_cyc = cyc;
    end
    case (o_acc_state)
      2'b01: begin
        n_wgt++;
        chk("wgt_en", o_acc_data_en, 1);
        chk("wgt_has_word", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          w_exp = wq.pop_front();
          chk("wgt_data", o_acc_data, {80'b0, w_exp});
        end
      end
      2'b10: begin
        n_full++;
        chk("fill_en", o_acc_data_en, 0);
      end
      2'b11: begin
        if (o_acc_data_en) begin
          n_conv++;
          chk("img_has_beat", iq.size() > 0, 1);
          if (iq.size() > 0) begin
            i_exp = iq.pop_front();
            chk("img_data", o_acc_data, i_exp);
          end
        end
      end
      default: chk("ctrl_en", o_acc_data_en, 0);
    endcase
    if (o_acc_last) begin
      n_last++;
      last_cyc = cyc;
      chk("last_en", o_acc_data_en, 0);
    end
    if (o_job_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (o_res_valid) begin
      chk("res_expected", rq.size() > 0, 1);
      if (rq.size() > 0) begin
        r_exp = rq.pop_front();
        chk("res_data", o_res_data, r_exp.d);
        chk("res_lat", cyc, r_exp.c + 1);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, o_busy, 0);
    chk({tag, "_done"}, o_job_done, 0);
    chk({tag, "_err"}, o_err, 0);
    chk({tag, "_wready"}, o_w_ready, 0);
    chk({tag, "_iready"}, o_img_ready, 0);
    chk({tag, "_accrst"}, o_acc_rst, 0);
    chk({tag, "_accst"}, o_acc_state, 0);
    chk({tag, "_accdata"}, o_acc_data, 0);
    chk({tag, "_accen"}, o_acc_data_en, 0);
    chk({tag, "_acclast"}, o_acc_last, 0);
    chk({tag, "_resv"}, o_res_valid, 0);
    chk({tag, "_resd"}, o_res_data, 0);
    chk({tag, "_rescnt"}, o_res_cnt, 0);
  endtask

  // One job. done_wait<0: done never raised. abort_beat>=0: async reset after
  // that many accepted image beats. dbl: second start pulsed mid-CONV.
  task automatic run_job(input int tiles, input bit w_toggle, input int img_pct,
                         input int done_wait, input int abort_beat, input bit dbl);
    int s, wsent, bsent, tot, last_acc, exp_wait;
    n_wgt = 0; n_full = 0; n_conv = 0; n_rst = 0; n_last = 0; n_done = 0;
    tot = tiles * 16;
    wsent = 0; bsent = 0; last_acc = -1;
    i_start = 1'b1;
    i_tile_num = 8'(tiles);
    @(posedge clk); #1;
    s = cyc;
    i_start = 1'b0;
    i_tile_num = 8'($urandom);
    chk("clr_busy", o_busy, 1);
    chk("clr_accrst", o_acc_rst, 1);
    chk("clr_err", o_err, 0);
    chk("clr_rescnt", o_res_cnt, 0);
    for (int k = 0; k < 3000 && n_done == 0; k++) begin
      if (abort_beat >= 0 && bsent == abort_beat) begin
        rst = 1'b0;
        #1;
        check_all_zero("abort");
        i_w_valid = 1'b0;
        i_img_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_idle", o_busy, 0);
        wq.delete();
        iq.delete();
        return;
      end
      i_w_valid = (wsent < 9) && (w_toggle ? (cyc % 2 == 0) : 1'b1);
      i_w_data  = {$urandom, $urandom};
      if (i_w_valid && o_w_ready) begin
        wq.push_back(i_w_data);
        wsent++;
      end
      i_img_valid = (bsent < tot) && ($urandom_range(99) < img_pct);
      i_img_data  = IMG_W'({$urandom, $urandom, $urandom, $urandom, $urandom});
      if (i_img_valid && o_img_ready) begin
        iq.push_back(i_img_data);
        bsent++;
        if (bsent == tot) last_acc = cyc;
      end
      i_start = dbl && (bsent == 5);
      i_tile_num = 8'd7;
      i_acc_done = (n_last > 0) && (done_wait >= 0) && (cyc >= last_cyc + done_wait);
      @(posedge clk); #1;
    end
    i_acc_done = 1'b0;
    i_w_valid = 1'b0;
    i_img_valid = 1'b0;
    i_start = 1'b0;
    exp_wait = (done_wait < 0 || done_wait > 254) ? 255 : done_wait + 1;
    chk("job_done", n_done, 1);
    chk("n_accrst", n_rst, 1);
    chk("accrst_cyc", rst_cyc, s);
    chk("n_weight", n_wgt, 9);
    chk("n_fullup", n_full, 1);
    chk("n_conv_en", n_conv, tot);
    chk("n_last", n_last, 1);
    chk("last_lat", last_cyc, last_acc + 2);
    chk("done_lat", done_cyc - last_cyc, exp_wait);
    chk("err", o_err, done_wait < 0);
    chk("idle_after", o_busy, 0);
    chk("wq_drained", wq.size(), 0);
    chk("iq_drained", iq.size(), 0);
    if (!w_toggle && img_pct >= 100) begin
      chk("job_len", done_cyc - s + 1, 13 + 16 * tiles + exp_wait);
    end
  endtask

  task automatic res_burst(input int n);
    int sent;
    sent = 0;
    for (int k = 0; k < 1000 && sent < n; k++) begin
      i_acc_out_en = 1'($urandom_range(1));
      i_acc_out_data = {$urandom, $urandom};
      if (i_acc_out_en) begin
        rq.push_back('{i_acc_out_data, cyc});
        sent++;
      end
      @(posedge clk); #1;
    end
    i_acc_out_en = 1'b0;
    @(posedge clk); #1;
    chk("res_cnt", o_res_cnt, 16'(n));
    chk("res_drained", rq.size(), 0);
  endtask

  initial begin
    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    run_job(1, 1'b0, 100, 20, -1, 1'b0);

    for (int k = 0; k < 4; k++) begin
      i_start = 1'b1;
      i_tile_num = 8'd0;
      @(posedge clk); #1;
      chk("zero_busy", o_busy, 0);
      chk("zero_accrst", o_acc_rst, 0);
      chk("zero_wready", o_w_ready, 0);
      chk("zero_accen", o_acc_data_en, 0);
    end
    i_start = 1'b0;
    @(posedge clk); #1;

    run_job(2, 1'b1, 100, 254, -1, 1'b0);
    run_job(1, 1'b0, 70, -1, -1, 1'b0);
    run_job(3, 1'b0, 80, 10, 20, 1'b0);
    run_job(1, 1'b0, 100, 3, -1, 1'b0);
    run_job(2, 1'b0, 60, int'($urandom_range(50, 1)), -1, 1'b1);
    res_burst(64);
    run_job(1, 1'b1, 75, 5, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
